// File: rtl/alu_exec_unit.sv
// Execute stage feeding the register file write port: single-cycle logic/add ops,
// iterative MUL/MULH and, when ALU_DIV_EN is defined, iterative DIVU/REMU.
module alu_exec_unit #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned AW    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [AW-1:0]    in_dest,
    output logic             wb_en,
    output logic [AW-1:0]    wb_addr,
    output logic [WIDTH-1:0] wb_data,
    output logic             wb_zero,
    output logic             wb_carry,
    output logic             wb_ovf,
    output logic             wb_illegal,
    output logic             busy
);
    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam int unsigned SW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_WB} state_e;
    typedef enum logic [3:0] {
        OP_ADD  = 4'h0, OP_SUB  = 4'h1, OP_AND  = 4'h2, OP_OR   = 4'h3,
        OP_XOR  = 4'h4, OP_SLL  = 4'h5, OP_SRL  = 4'h6, OP_SRA  = 4'h7,
        OP_SLT  = 4'h8, OP_SLTU = 4'h9, OP_PASS = 4'hA, OP_MUL  = 4'hB,
        OP_MULH = 4'hC, OP_DIVU = 4'hD, OP_REMU = 4'hE, OP_ILL  = 4'hF
    } op_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    op_e              op_q, op_d;
    logic [AW-1:0]    dest_q, dest_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             wb_en_q, wb_en_d;
    logic [AW-1:0]    wb_addr_q, wb_addr_d;
    logic [WIDTH-1:0] wb_data_q, wb_data_d;
    logic             wb_zero_q, wb_zero_d, wb_carry_q, wb_carry_d;
    logic             wb_ovf_q, wb_ovf_d, wb_ill_q, wb_ill_d;

    op_e              in_opc;
    logic             accept, in_multi, in_illegal;
    logic [SW-1:0]    shamt;
    logic [WIDTH-1:0] b_eff, sc_res, hi_step, lo_step, it_res;
    logic [WIDTH:0]   sum, mul_sum;
    logic             sc_carry, sc_ovf;
`ifdef ALU_DIV_EN
    logic [WIDTH:0]   div_sh;
`endif

    assign in_opc   = op_e'(in_op);
    assign in_ready = (state_q != S_BUSY);
    assign busy     = (state_q == S_BUSY);
    assign accept   = in_valid && in_ready;
    assign shamt    = in_b[SW-1:0];

`ifdef ALU_DIV_EN
    assign in_multi   = (in_opc == OP_MUL) || (in_opc == OP_MULH) ||
                        (in_opc == OP_DIVU) || (in_opc == OP_REMU);
    assign in_illegal = (in_opc == OP_ILL);
`else
    assign in_multi   = (in_opc == OP_MUL) || (in_opc == OP_MULH);
    assign in_illegal = (in_opc == OP_ILL) || (in_opc == OP_DIVU) || (in_opc == OP_REMU);
`endif

    always_comb begin
        b_eff    = (in_opc == OP_SUB) ? ~in_b : in_b;
        sum      = {1'b0, in_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, (in_opc == OP_SUB)};
        sc_res   = '0;
        sc_carry = 1'b0;
        sc_ovf   = 1'b0;
        case (in_opc)
            OP_ADD, OP_SUB: begin
                sc_res   = sum[WIDTH-1:0];
                sc_carry = sum[WIDTH];
                sc_ovf   = (in_a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != in_a[WIDTH-1]);
            end
            OP_AND:  sc_res = in_a & in_b;
            OP_OR:   sc_res = in_a | in_b;
            OP_XOR:  sc_res = in_a ^ in_b;
            OP_SLL:  sc_res = in_a << shamt;
            OP_SRL:  sc_res = in_a >> shamt;
            OP_SRA:  sc_res = $signed(in_a) >>> shamt;
            OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
            OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (in_a < in_b)};
            OP_PASS: sc_res = in_b;
            default: sc_res = '0;
        endcase
    end

    // hi/lo form one shift register: {partial product, multiplier} for MUL,
    // {remainder, dividend->quotient} for DIV. opnd_q is multiplicand or divisor.
    always_comb begin
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        hi_step = mul_sum[WIDTH:1];
        lo_step = {mul_sum[0], lo_q[WIDTH-1:1]};
`ifdef ALU_DIV_EN
        div_sh = {hi_q, lo_q[WIDTH-1]};
        if (op_q == OP_DIVU || op_q == OP_REMU) begin
            // Divisor 0 never borrows: quotient fills with ones, remainder ends as in_a.
            if (div_sh >= {1'b0, opnd_q}) begin
                hi_step = div_sh[WIDTH-1:0] - opnd_q;
                lo_step = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_step = div_sh[WIDTH-1:0];
                lo_step = {lo_q[WIDTH-2:0], 1'b0};
            end
        end
`endif
        it_res = (op_q == OP_MULH || op_q == OP_REMU) ? hi_step : lo_step;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        dest_d     = dest_q;
        opnd_d     = opnd_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        wb_en_d    = 1'b0;
        wb_addr_d  = wb_addr_q;
        wb_data_d  = wb_data_q;
        wb_zero_d  = wb_zero_q;
        wb_carry_d = wb_carry_q;
        wb_ovf_d   = wb_ovf_q;
        wb_ill_d   = wb_ill_q;
        case (state_q)
            S_BUSY: begin
                hi_d  = hi_step;
                lo_d  = lo_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d    = S_WB;
                    wb_en_d    = 1'b1;
                    wb_addr_d  = dest_q;
                    wb_data_d  = it_res;
                    wb_zero_d  = (it_res == '0);
                    wb_carry_d = 1'b0;
                    wb_ovf_d   = 1'b0;
                    wb_ill_d   = (op_q == OP_DIVU || op_q == OP_REMU) && (opnd_q == '0);
                end
            end
            default: begin
                state_d = S_IDLE;
                if (accept && in_multi) begin
                    state_d = S_BUSY;
                    cnt_d   = '0;
                    op_d    = in_opc;
                    dest_d  = in_dest;
                    hi_d    = '0;
                    opnd_d  = (in_opc == OP_MUL || in_opc == OP_MULH) ? in_a : in_b;
                    lo_d    = (in_opc == OP_MUL || in_opc == OP_MULH) ? in_b : in_a;
                end else if (accept) begin
                    wb_en_d    = 1'b1;
                    wb_addr_d  = in_dest;
                    wb_data_d  = sc_res;
                    wb_zero_d  = (sc_res == '0);
                    wb_carry_d = sc_carry;
                    wb_ovf_d   = sc_ovf;
                    wb_ill_d   = in_illegal;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            op_q       <= OP_ADD;
            dest_q     <= '0;
            opnd_q     <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            wb_en_q    <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
            wb_zero_q  <= 1'b0;
            wb_carry_q <= 1'b0;
            wb_ovf_q   <= 1'b0;
            wb_ill_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            dest_q     <= dest_d;
            opnd_q     <= opnd_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            wb_en_q    <= wb_en_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
            wb_zero_q  <= wb_zero_d;
            wb_carry_q <= wb_carry_d;
            wb_ovf_q   <= wb_ovf_d;
            wb_ill_q   <= wb_ill_d;
        end
    end

    assign wb_en      = wb_en_q;
    assign wb_addr    = wb_addr_q;
    assign wb_data    = wb_data_q;
    assign wb_zero    = wb_zero_q;
    assign wb_carry   = wb_carry_q;
    assign wb_ovf     = wb_ovf_q;
    assign wb_illegal = wb_ill_q;

endmodule
